// File: rtl/datamover_ctrl_fsm_pkg.sv
// rtl/datamover_ctrl_fsm_pkg.sv - types shared by the datamover job sequencer
package datamover_ctrl_fsm_pkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    FINISH   = 3'd4
  } datamover_state_e;

  typedef struct packed {
    logic [31:0]      src_base;
    logic [31:0]      dst_base;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] nb_tiles;
    logic [31:0]      src_stride;
    logic [31:0]      dst_stride;
  } ctrl_fsm_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } stream_flags_t;

  typedef struct packed {
    stream_flags_t data_in;
    stream_flags_t data_out;
    logic          tcdm_fifo_empty;
  } flags_streamer_t;

  typedef struct packed {
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] tot_len;
    logic [LEN_W-1:0] d0_len;
    logic [31:0]      d0_stride;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } stream_ctrl_t;

  typedef struct packed {
    stream_ctrl_t data_in;
    stream_ctrl_t data_out;
  } ctrl_streamer_t;

  typedef struct packed {
    datamover_state_e state;
    logic [LEN_W-1:0] tile_cnt;
  } flags_fsm_t;

endpackage

// File: rtl/datamover_ctrl_fsm.sv
// rtl/datamover_ctrl_fsm.sv - tile-by-tile job sequencer driving the datamover streamer
module datamover_ctrl_fsm
  import datamover_ctrl_fsm_pkg::*;
#(
  parameter int unsigned BW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic            start_i,
  input  ctrl_fsm_t       cfg_i,
  input  flags_streamer_t flags_streamer_i,
  output ctrl_streamer_t  ctrl_streamer_o,
  output logic            busy_o,
  output logic            done_o,
  output flags_fsm_t      flags_o
);

  localparam logic [31:0] WORD_BYTES = 32'(BW / 8);

  datamover_state_e state_q, state_d;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] nb_tiles_q;
  logic [31:0]      src_stride_q;
  logic [31:0]      dst_stride_q;
  logic [31:0]      cur_src_q;
  logic [31:0]      cur_dst_q;
  logic [LEN_W-1:0] tile_cnt_q;
  logic             in_done_q;
  logic             out_done_q;

  logic in_seen;
  logic out_seen;
  logic both_ready;
  logic last_tile;
  logic fifo_empty;
  logic req_start;

  // A done pulse counts in the cycle it arrives, so both may land together.
  assign in_seen    = in_done_q  | flags_streamer_i.data_in.done;
  assign out_seen   = out_done_q | flags_streamer_i.data_out.done;
  assign both_ready = flags_streamer_i.data_in.ready_start & flags_streamer_i.data_out.ready_start;
  assign fifo_empty = flags_streamer_i.tcdm_fifo_empty;
  assign last_tile  = (tile_cnt_q == nb_tiles_q - LEN_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_start = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_i.len == '0 || cfg_i.nb_tiles == '0) state_d = FINISH;
          else                                          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (both_ready) begin
          req_start = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (in_seen && out_seen) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = last_tile ? FINISH : WAIT_RDY;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Freeze: a pending request simply reissues once enable returns.
    if (!enable_i) begin
      state_d   = state_q;
      req_start = 1'b0;
      done_o    = 1'b0;
    end
    if (clear_i) begin
      state_d   = IDLE;
      req_start = 1'b0;
      done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q        <= '0;
      nb_tiles_q   <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      tile_cnt_q   <= '0;
      in_done_q    <= 1'b0;
      out_done_q   <= 1'b0;
    end else if (clear_i) begin
      tile_cnt_q <= '0;
      in_done_q  <= 1'b0;
      out_done_q <= 1'b0;
    end else begin
      // Done capture keeps running while frozen so no pulse is lost.
      if (state_q == STREAM) begin
        if (enable_i && in_seen && out_seen) begin
          in_done_q  <= 1'b0;
          out_done_q <= 1'b0;
        end else begin
          in_done_q  <= in_seen;
          out_done_q <= out_seen;
        end
      end
      if (enable_i) begin
        if (state_q == IDLE && start_i) begin
          len_q        <= cfg_i.len;
          nb_tiles_q   <= cfg_i.nb_tiles;
          src_stride_q <= cfg_i.src_stride;
          dst_stride_q <= cfg_i.dst_stride;
          cur_src_q    <= cfg_i.src_base;
          cur_dst_q    <= cfg_i.dst_base;
          tile_cnt_q   <= '0;
        end else if (state_q == DRAIN && fifo_empty && !last_tile) begin
          tile_cnt_q <= tile_cnt_q + LEN_W'(1);
          cur_src_q  <= cur_src_q + src_stride_q;
          cur_dst_q  <= cur_dst_q + dst_stride_q;
        end
      end
    end
  end

  always_comb begin
    ctrl_streamer_o = '0;
    ctrl_streamer_o.data_in.req_start                 = req_start;
    ctrl_streamer_o.data_in.addressgen_ctrl.base_addr = cur_src_q;
    ctrl_streamer_o.data_in.addressgen_ctrl.tot_len   = len_q;
    ctrl_streamer_o.data_in.addressgen_ctrl.d0_len    = len_q;
    ctrl_streamer_o.data_in.addressgen_ctrl.d0_stride = (state_q == IDLE) ? '0 : WORD_BYTES;
    ctrl_streamer_o.data_out.req_start                 = req_start;
    ctrl_streamer_o.data_out.addressgen_ctrl.base_addr = cur_dst_q;
    ctrl_streamer_o.data_out.addressgen_ctrl.tot_len   = len_q;
    ctrl_streamer_o.data_out.addressgen_ctrl.d0_len    = len_q;
    ctrl_streamer_o.data_out.addressgen_ctrl.d0_stride = (state_q == IDLE) ? '0 : WORD_BYTES;
  end

  assign busy_o           = (state_q != IDLE);
  assign flags_o.state    = state_q;
  assign flags_o.tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_datamover_ctrl_fsm.sv
// tb/tb_datamover_ctrl_fsm.sv - directed self-checking bench for datamover_ctrl_fsm
module tb_datamover_ctrl_fsm;
  import datamover_ctrl_fsm_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            enable;
  logic            start;
  ctrl_fsm_t       cfg;
  flags_streamer_t fl;
  ctrl_streamer_t  ctrl;
  logic            busy;
  logic            done;
  flags_fsm_t      flags;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;
  int done_cnt = 0;

  datamover_ctrl_fsm #(.BW(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .enable_i         (enable),
    .start_i          (start),
    .cfg_i            (cfg),
    .flags_streamer_i (fl),
    .ctrl_streamer_o  (ctrl),
    .busy_o           (busy),
    .done_o           (done),
    .flags_o          (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (ctrl.data_in.req_start) req_cnt <= req_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_fsm_t mk_cfg(input logic [31:0] src, input logic [31:0] dst,
                                       input logic [15:0] len, input logic [15:0] nb,
                                       input logic [31:0] ss, input logic [31:0] ds);
    ctrl_fsm_t c;
    c.src_base = src; c.dst_base = dst; c.len = len; c.nb_tiles = nb;
    c.src_stride = ss; c.dst_stride = ds;
    return c;
  endfunction

  task automatic start_job(input ctrl_fsm_t c);
    cfg = c;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  // From WAIT_RDY with both sides ready: run one tile and leave DRAIN.
  task automatic finish_tile();
    step();
    fl.data_in.done = 1'b1; fl.data_out.done = 1'b1;
    step();
    fl.data_in.done = 1'b0; fl.data_out.done = 1'b0;
    step();
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (flags.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", flags.state, IDLE); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_tests++; if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
    n_tests++; if (flags.tile_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_tile: got %0d want 0", flags.tile_cnt); end
  endtask

  task automatic test_single_tile();
    int r0 = req_cnt, d0 = done_cnt;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd16, 16'd1, 32'h0, 32'h0));
    n_tests++; if (ctrl.data_in.req_start !== 1'b1 || ctrl.data_out.req_start !== 1'b1) begin n_fail++; $display("FAIL t1_req: got %0b/%0b want 1/1", ctrl.data_in.req_start, ctrl.data_out.req_start); end
    n_tests++; if (ctrl.data_in.addressgen_ctrl.base_addr !== 32'h1000) begin n_fail++; $display("FAIL t1_src: got %h want 00001000", ctrl.data_in.addressgen_ctrl.base_addr); end
    n_tests++; if (ctrl.data_out.addressgen_ctrl.base_addr !== 32'h2000) begin n_fail++; $display("FAIL t1_dst: got %h want 00002000", ctrl.data_out.addressgen_ctrl.base_addr); end
    n_tests++; if (ctrl.data_in.addressgen_ctrl.tot_len !== 16'd16 || ctrl.data_out.addressgen_ctrl.d0_len !== 16'd16) begin n_fail++; $display("FAIL t1_len: got %0d/%0d want 16/16", ctrl.data_in.addressgen_ctrl.tot_len, ctrl.data_out.addressgen_ctrl.d0_len); end
    n_tests++; if (ctrl.data_in.addressgen_ctrl.d0_stride !== 32'd4) begin n_fail++; $display("FAIL t1_stride: got %0d want 4", ctrl.data_in.addressgen_ctrl.d0_stride); end
    step();
    n_tests++; if (ctrl.data_in.req_start !== 1'b0 || flags.state !== STREAM) begin n_fail++; $display("FAIL t1_stream: req %0b state %0d want 0/%0d", ctrl.data_in.req_start, flags.state, STREAM); end
    fl.data_in.done = 1'b1; fl.data_out.done = 1'b1;
    step();
    fl.data_in.done = 1'b0; fl.data_out.done = 1'b0;
    #1;
    n_tests++; if (flags.state !== DRAIN || done !== 1'b0) begin n_fail++; $display("FAIL t1_drain: state %0d done %0b want %0d/0", flags.state, done, DRAIN); end
    step();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t1_done: got %0b want 1", done); end
    step();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle: done %0b busy %0b want 0/0", done, busy); end
    n_tests++; if (req_cnt - r0 !== 1 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL t1_counts: req %0d done %0d want 1/1", req_cnt - r0, done_cnt - d0); end
  endtask

  task automatic test_multi_tile();
    logic [31:0] exp_src [3] = '{32'h1000, 32'h1040, 32'h1080};
    logic [31:0] exp_dst [3] = '{32'h2000, 32'h2080, 32'h2100};
    int r0 = req_cnt, d0 = done_cnt;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd8, 16'd3, 32'h40, 32'h80));
    for (int t = 0; t < 3; t++) begin
      n_tests++; if (ctrl.data_in.addressgen_ctrl.base_addr !== exp_src[t] || ctrl.data_out.addressgen_ctrl.base_addr !== exp_dst[t]) begin n_fail++; $display("FAIL t2_base%0d: got %h/%h want %h/%h", t, ctrl.data_in.addressgen_ctrl.base_addr, ctrl.data_out.addressgen_ctrl.base_addr, exp_src[t], exp_dst[t]); end
      n_tests++; if (flags.tile_cnt !== 16'(t)) begin n_fail++; $display("FAIL t2_tile%0d: got %0d want %0d", t, flags.tile_cnt, t); end
      finish_tile();
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t2_done: got %0b want 1", done); end
    step();
    n_tests++; if (req_cnt - r0 !== 3 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL t2_counts: req %0d done %0d want 3/1", req_cnt - r0, done_cnt - d0); end
  endtask

  task automatic test_done_order();
    for (int o = 0; o < 2; o++) begin
      int d0 = done_cnt;
      start_job(mk_cfg(32'h1000, 32'h2000, 16'd4, 16'd1, 32'h0, 32'h0));
      step();
      if (o == 0) fl.data_in.done = 1'b1; else fl.data_out.done = 1'b1;
      step();
      fl.data_in.done = 1'b0; fl.data_out.done = 1'b0;
      repeat (5) step();
      n_tests++; if (flags.state !== STREAM) begin n_fail++; $display("FAIL t3_wait%0d: state %0d want %0d", o, flags.state, STREAM); end
      if (o == 0) fl.data_out.done = 1'b1; else fl.data_in.done = 1'b1;
      step();
      fl.data_in.done = 1'b0; fl.data_out.done = 1'b0;
      #1;
      n_tests++; if (flags.state !== DRAIN) begin n_fail++; $display("FAIL t3_drain%0d: state %0d want %0d", o, flags.state, DRAIN); end
      step(); step();
      n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL t3_done%0d: got %0d want 1", o, done_cnt - d0); end
    end
  endtask

  task automatic test_fifo_drain();
    int r0, d0;
    fl.tcdm_fifo_empty = 1'b0;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd4, 16'd2, 32'h40, 32'h80));
    step();
    fl.data_in.done = 1'b1; fl.data_out.done = 1'b1;
    step();
    fl.data_in.done = 1'b0; fl.data_out.done = 1'b0;
    r0 = req_cnt; d0 = done_cnt;
    repeat (10) step();
    n_tests++; if (flags.state !== DRAIN || req_cnt != r0 || done_cnt != d0) begin n_fail++; $display("FAIL t4_hold: state %0d req %0d done %0d want %0d/0/0", flags.state, req_cnt - r0, done_cnt - d0, DRAIN); end
    fl.tcdm_fifo_empty = 1'b1;
    step();
    n_tests++; if (flags.state !== WAIT_RDY || ctrl.data_in.req_start !== 1'b1 || flags.tile_cnt !== 16'd1) begin n_fail++; $display("FAIL t4_next: state %0d req %0b tile %0d want %0d/1/1", flags.state, ctrl.data_in.req_start, flags.tile_cnt, WAIT_RDY); end
    n_tests++; if (ctrl.data_in.addressgen_ctrl.base_addr !== 32'h1040) begin n_fail++; $display("FAIL t4_base: got %h want 00001040", ctrl.data_in.addressgen_ctrl.base_addr); end
    finish_tile();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t4_done: got %0b want 1", done); end
    step();
  endtask

  task automatic test_zero_and_wrap();
    int r0 = req_cnt;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd0, 16'd1, 32'h0, 32'h0));
    n_tests++; if (flags.state !== FINISH || done !== 1'b1 || ctrl.data_in.req_start !== 1'b0) begin n_fail++; $display("FAIL t5_zero_len: state %0d done %0b req %0b want %0d/1/0", flags.state, done, ctrl.data_in.req_start, FINISH); end
    step();
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd4, 16'd0, 32'h0, 32'h0));
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL t5_zero_tiles: done %0b want 1", done); end
    step();
    n_tests++; if (req_cnt != r0 || done !== 1'b0) begin n_fail++; $display("FAIL t5_noreq: req %0d done %0b want 0/0", req_cnt - r0, done); end
    start_job(mk_cfg(32'hFFFF_FFC0, 32'hFFFF_FF00, 16'd4, 16'd2, 32'h80, 32'h100));
    finish_tile();
    n_tests++; if (ctrl.data_in.addressgen_ctrl.base_addr !== 32'h0000_0040 || ctrl.data_out.addressgen_ctrl.base_addr !== 32'h0) begin n_fail++; $display("FAIL t5_wrap: got %h/%h want 00000040/00000000", ctrl.data_in.addressgen_ctrl.base_addr, ctrl.data_out.addressgen_ctrl.base_addr); end
    finish_tile();
    step();
  endtask

  task automatic test_clear();
    int d0 = done_cnt;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd4, 16'd2, 32'h40, 32'h80));
    step();
    fl.data_in.done = 1'b1;
    step();
    fl.data_in.done = 1'b0;
    clear = 1'b1; fl.data_out.done = 1'b1;
    step();
    clear = 1'b0; fl.data_out.done = 1'b0;
    #1;
    n_tests++; if (flags.state !== IDLE || busy !== 1'b0 || flags.tile_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_clear: state %0d busy %0b tile %0d want %0d/0/0", flags.state, busy, flags.tile_cnt, IDLE); end
    repeat (3) step();
    n_tests++; if (done_cnt != d0) begin n_fail++; $display("FAIL t6_nodone: got %0d want 0", done_cnt - d0); end
    start_job(mk_cfg(32'h3000, 32'h4000, 16'd4, 16'd2, 32'h40, 32'h80));
    n_tests++; if (ctrl.data_in.addressgen_ctrl.base_addr !== 32'h3000 || flags.tile_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_restart: base %h tile %0d want 00003000/0", ctrl.data_in.addressgen_ctrl.base_addr, flags.tile_cnt); end
    step();
    fl.data_out.done = 1'b1;
    step();
    fl.data_out.done = 1'b0;
    #1;
    n_tests++; if (flags.state !== STREAM) begin n_fail++; $display("FAIL t6_sticky: state %0d want %0d", flags.state, STREAM); end
    fl.data_in.done = 1'b1;
    step();
    fl.data_in.done = 1'b0;
    step();
    n_tests++; if (ctrl.data_out.addressgen_ctrl.base_addr !== 32'h4080 || flags.tile_cnt !== 16'd1) begin n_fail++; $display("FAIL t6_tile1: base %h tile %0d want 00004080/1", ctrl.data_out.addressgen_ctrl.base_addr, flags.tile_cnt); end
    finish_tile();
    step();
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL t6_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_enable();
    fl.data_in.ready_start = 1'b0; fl.data_out.ready_start = 1'b0;
    start_job(mk_cfg(32'h1000, 32'h2000, 16'd4, 16'd1, 32'h0, 32'h0));
    n_tests++; if (ctrl.data_in.req_start !== 1'b0) begin n_fail++; $display("FAIL te_notready: req %0b want 0", ctrl.data_in.req_start); end
    enable = 1'b0;
    fl.data_in.ready_start = 1'b1; fl.data_out.ready_start = 1'b1;
    step(); step();
    n_tests++; if (ctrl.data_in.req_start !== 1'b0 || flags.state !== WAIT_RDY) begin n_fail++; $display("FAIL te_frozen: req %0b state %0d want 0/%0d", ctrl.data_in.req_start, flags.state, WAIT_RDY); end
    enable = 1'b1;
    #1;
    n_tests++; if (ctrl.data_in.req_start !== 1'b1) begin n_fail++; $display("FAIL te_resume: req %0b want 1", ctrl.data_in.req_start); end
    finish_tile();
    step();
  endtask

  task automatic test_async_reset();
    start_job(mk_cfg(32'h5000, 32'h6000, 16'd4, 16'd2, 32'h0, 32'h0));
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (flags.state !== IDLE || busy !== 1'b0 || ctrl !== '0) begin n_fail++; $display("FAIL ar_state: state %0d busy %0b ctrl %h want %0d/0/0", flags.state, busy, ctrl, IDLE); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; start = 1'b0;
    cfg = '0;
    fl = '0;
    fl.data_in.ready_start = 1'b1; fl.data_out.ready_start = 1'b1; fl.tcdm_fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_single_tile();
    test_multi_tile();
    test_done_order();
    test_fifo_drain();
    test_zero_and_wrap();
    test_clear();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
